// File: rtl/seq_ctrl.sv
// seq_ctrl: fetch/decode/execute sequencer for the phase datapath.
// Drives the 13-bit control word (R, DR, PC, AC, OPR demux, IRAM, WTA, ALU),
// handles IRAM wait states, branch-on-zero, halt, illegal-opcode and timeout
// faults, and counts retired instructions.
// Optional build macro SEQ_STEP_EN: adds a 'step' input that gates each fetch.
module seq_ctrl #(
    parameter int CTRL_W   = 13,
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_ready,
`ifdef SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [7:0]        instr,
    input  logic              z,
    output logic [CTRL_W-1:0] ctrlsig,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        fault,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_XWAIT  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_OPR  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int              WCNT_W    = $clog2(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              wait_last;
    logic              z_q;
    logic [1:0]        fault_q, fault_nxt;
    logic [CNT_W-1:0]  retired_q;
    logic [3:0]        opcode;

    // Individual control-word fields, packed into ctrlsig below.
    logic       r_we, dr_we, pc_we, ac_we, iram_rd, wta_en, pc_inc;
    logic [2:0] opr_sel, alu_op;

    // Operand bit 3 carries no meaning for any opcode this sequencer decodes.
    logic unused_operand;
    assign unused_operand = instr[3];

    assign opcode    = instr[7:4];
    assign wait_last = (wait_cnt == WAIT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and next-fault decode.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        fault_nxt = fault_q;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
`ifdef SEQ_STEP_EN
            S_FETCH:  if (step) state_nxt = S_FWAIT;
`else
            S_FETCH:  state_nxt = S_FWAIT;
`endif
            S_FWAIT: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (wait_last) begin
                    state_nxt = S_HALT;
                    fault_nxt = F_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                    fault_nxt = F_NONE;
                end else if (opcode > OP_OPR) begin
                    state_nxt = S_HALT;
                    fault_nxt = F_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LDR || opcode == OP_JMP || (opcode == OP_JZ && z_q))
                    state_nxt = S_XWAIT;
                else
                    state_nxt = S_FETCH;
            end
            S_XWAIT: begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (wait_last) begin
                    state_nxt = S_HALT;
                    fault_nxt = F_TIMEOUT;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    fault_nxt = F_NONE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Wait counter, latched zero flag, fault code and retired count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            z_q       <= 1'b0;
            fault_q   <= F_NONE;
            retired_q <= '0;
        end else begin
            if (state == S_FETCH || (state == S_EXEC && state_nxt == S_XWAIT))
                wait_cnt <= '0;
            else if ((state == S_FWAIT || state == S_XWAIT) && !mem_ready && !wait_last)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_DECODE)
                z_q <= z;
            fault_q <= fault_nxt;
            if ((state == S_EXEC || state == S_XWAIT) && state_nxt == S_FETCH)
                retired_q <= retired_q + 1'b1;
        end
    end

    // Per-state control word decode.
    always_comb begin
        r_we    = 1'b0;
        dr_we   = 1'b0;
        pc_we   = 1'b0;
        ac_we   = 1'b0;
        iram_rd = 1'b0;
        wta_en  = 1'b0;
        pc_inc  = 1'b0;
        opr_sel = 3'd0;
        alu_op  = 3'd0;
        case (state)
`ifdef SEQ_STEP_EN
            S_FETCH: iram_rd = step;
`else
            S_FETCH: iram_rd = 1'b1;
`endif
            S_FWAIT: begin
                iram_rd = 1'b1;
                if (mem_ready) begin
                    dr_we  = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_ALU: begin
                        wta_en  = 1'b1;
                        opr_sel = 3'd3;
                        alu_op  = instr[2:0];
                        ac_we   = 1'b1;
                    end
                    OP_OPR:         opr_sel = instr[2:0];
                    OP_LDR, OP_JMP: iram_rd = 1'b1;
                    OP_JZ: begin
                        // Taken branch reads the target word; not taken skips it.
                        if (z_q) iram_rd = 1'b1;
                        else     pc_inc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_XWAIT: begin
                iram_rd = 1'b1;
                if (mem_ready) begin
                    if (opcode == OP_LDR) begin
                        r_we   = 1'b1;
                        pc_inc = 1'b1;
                    end else begin
                        pc_we  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ctrlsig   = {pc_inc, alu_op, wta_en, iram_rd, opr_sel, ac_we, pc_we, dr_we, r_we};
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign fault     = fault_q;
    assign retired   = retired_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl (default build, no step port).
// An instruction-level model expands each instruction into its expected
// per-cycle control words; one negedge process compares the DUT against it.
module tb_seq_ctrl;

    localparam int WM = 4;
    localparam int CW = 2;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_FWAIT = 3'd2,
                           ST_DECODE = 3'd3, ST_EXEC = 3'd4, ST_XWAIT = 3'd5,
                           ST_HALT = 3'd6;

    localparam logic [12:0] M_RWE   = 13'h0001;
    localparam logic [12:0] M_DRWE  = 13'h0002;
    localparam logic [12:0] M_PCWE  = 13'h0004;
    localparam logic [12:0] M_ACWE  = 13'h0008;
    localparam logic [12:0] M_IRD   = 13'h0080;
    localparam logic [12:0] M_WTA   = 13'h0100;
    localparam logic [12:0] M_PCINC = 13'h1000;

    logic        clk = 1'b0;
    logic        reset, start, mem_ready, z;
    logic [7:0]  instr;
    logic [12:0] ctrlsig;
    logic        busy, halted;
    logic [1:0]  fault;
    logic [CW-1:0] retired;
    logic [2:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // Model state and per-cycle expectations.
    int          m_ret_total;
    logic [1:0]  m_fault;
    bit          chk_en = 1'b0;
    logic [12:0] exp_ctrl;
    logic [2:0]  exp_state;
    logic [1:0]  exp_fault;
    logic [CW-1:0] exp_ret;

    seq_ctrl #(.CTRL_W(13), .WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_ready (mem_ready),
        .instr     (instr),
        .z         (z),
        .ctrlsig   (ctrlsig),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Single compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrlsig",   ctrlsig,   exp_ctrl);
            check("state_dbg", state_dbg, exp_state);
            check("busy",      busy,      (exp_state != ST_IDLE) && (exp_state != ST_HALT));
            check("halted",    halted,    exp_state == ST_HALT);
            check("fault",     fault,     exp_fault);
            check("retired",   retired,   exp_ret);
        end
    end

    // Expected control word for the execute cycle of one instruction.
    function automatic logic [12:0] exec_word(input logic [7:0] ins, input logic zz);
        case (ins[7:4])
            4'h1:       return (13'(ins[2:0]) << 9) | M_WTA | (13'd3 << 4) | M_ACWE;
            4'h2, 4'h3: return M_IRD;
            4'h4:       return zz ? M_IRD : M_PCINC;
            4'h5:       return 13'(ins[2:0]) << 4;
            default:    return 13'h0;
        endcase
    endfunction

    // One clock cycle: drive inputs, publish expectations, advance.
    task automatic cyc(input logic i_start, input logic i_mr, input logic i_z,
                       input logic [12:0] e_ctrl, input logic [2:0] e_state);
        start     = i_start;
        mem_ready = i_mr;
        z         = i_z;
        exp_ctrl  = e_ctrl;
        exp_state = e_state;
        exp_fault = m_fault;
        exp_ret   = CW'(m_ret_total % (1 << CW));
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Memory wait of 'lat' unready cycles, then a ready cycle (or a timeout).
    task automatic wait_phase(input int lat, input logic [2:0] st, input logic [12:0] ready_word,
                              input logic zz, output bit timed_out);
        int n;
        n = (lat < WM) ? lat : WM;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, ~zz, M_IRD, st);
        if (lat >= WM) begin
            timed_out = 1'b1;
            m_fault   = 2'b10;
        end else begin
            cyc(1'b0, 1'b1, ~zz, ready_word, st);
        end
    endtask

    // Run one instruction from its FETCH cycle to completion or halt.
    task automatic run_instr(input logic [7:0] ins, input logic zz, input int flat, input int xlat);
        bit         to;
        logic [3:0] op;
        op    = ins[7:4];
        instr = ins;
        cyc(1'b0, 1'b1, ~zz, M_IRD, ST_FETCH);
        wait_phase(flat, ST_FWAIT, M_IRD | M_DRWE | M_PCINC, zz, to);
        if (to) return;
        cyc(1'b0, 1'b1, zz, 13'h0, ST_DECODE);
        if (op == 4'hF) begin m_fault = 2'b00; return; end
        if (op >= 4'h6) begin m_fault = 2'b01; return; end
        cyc(1'b0, 1'b1, ~zz, exec_word(ins, zz), ST_EXEC);
        if (op == 4'h2 || op == 4'h3 || (op == 4'h4 && zz)) begin
            wait_phase(xlat, ST_XWAIT,
                       (op == 4'h2) ? (M_IRD | M_RWE | M_PCINC) : (M_IRD | M_PCWE), zz, to);
            if (to) return;
        end
        m_ret_total++;
    endtask

    // Sit in HALT for a cycle, then restart with start=1.
    task automatic halt_resume();
        cyc(1'b0, 1'b1, 1'b0, 13'h0, ST_HALT);
        cyc(1'b1, 1'b1, 1'b0, 13'h0, ST_HALT);
        m_fault = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nop_seq[5];
        nop_seq = '{1, 2, 3, 0, 1};
        m_ret_total = 0;
        m_fault     = 2'b00;
        reset = 1'b0; start = 1'b0; mem_ready = 1'b0; z = 1'b0; instr = 8'h00;

        #3;
        check("rst_ctrlsig", ctrlsig, 0);
        check("rst_state",   state_dbg, 0);
        check("rst_busy",    busy, 0);
        check("rst_halted",  halted, 0);
        #19 reset = 1'b1;
        @(posedge clk); #1;

        // Idle without start, then launch with start held high throughout.
        cyc(1'b0, 1'b1, 1'b0, 13'h0, ST_IDLE);
        cyc(1'b0, 1'b1, 1'b0, 13'h0, ST_IDLE);
        cyc(1'b1, 1'b1, 1'b0, 13'h0, ST_IDLE);

        // ALU 0x12, literal words.
        instr = 8'h12;
        cyc(1'b1, 1'b1, 1'b0, 13'h080,  ST_FETCH);
        cyc(1'b1, 1'b1, 1'b0, 13'h1082, ST_FWAIT);
        cyc(1'b1, 1'b1, 1'b0, 13'h000,  ST_DECODE);
        cyc(1'b1, 1'b1, 1'b0, 13'h538,  ST_EXEC);
        m_ret_total++;
        check("alu_retired", retired, 1);

        // JZ taken, literal words; z flips after DECODE to prove it is latched.
        instr = 8'h40;
        cyc(1'b1, 1'b1, 1'b0, 13'h080,  ST_FETCH);
        cyc(1'b1, 1'b1, 1'b0, 13'h1082, ST_FWAIT);
        cyc(1'b1, 1'b1, 1'b1, 13'h000,  ST_DECODE);
        cyc(1'b1, 1'b1, 1'b0, 13'h080,  ST_EXEC);
        cyc(1'b1, 1'b1, 1'b0, 13'h084,  ST_XWAIT);
        m_ret_total++;

        // JZ not taken, literal words.
        cyc(1'b1, 1'b1, 1'b1, 13'h080,  ST_FETCH);
        cyc(1'b1, 1'b1, 1'b1, 13'h1082, ST_FWAIT);
        cyc(1'b1, 1'b1, 1'b0, 13'h000,  ST_DECODE);
        cyc(1'b1, 1'b1, 1'b1, 13'h1000, ST_EXEC);
        m_ret_total++;
        check("jz_nt_state", state_dbg, ST_FETCH);

        // Model-driven mix with wait states, including the longest legal wait.
        run_instr(8'h2A, 1'b0, 2, 3);
        check("ldr_wrap_retired", retired, 0);
        run_instr(8'h56, 1'b1, 1, 0);
        run_instr(8'h1F, 1'b0, 3, 0);
        run_instr(8'h3C, 1'b1, 0, 1);
        run_instr(8'h41, 1'b1, 1, 2);
        run_instr(8'h00, 1'b0, 0, 0);

        // Fetch timeout.
        run_instr(8'h00, 1'b0, 4, 0);
        check("fto_fault",  fault, 2'b10);
        check("fto_halted", halted, 1);
        halt_resume();

        // Execute-wait timeout.
        run_instr(8'h20, 1'b0, 0, 4);
        check("xto_fault", fault, 2'b10);
        halt_resume();

        // Illegal opcodes and HALT opcode.
        run_instr(8'h70, 1'b0, 0, 0);
        check("ill70_fault", fault, 2'b01);
        halt_resume();
        run_instr(8'hE5, 1'b1, 1, 0);
        halt_resume();
        run_instr(8'hF0, 1'b0, 0, 0);
        check("halt_fault",  fault, 2'b00);
        check("halt_halted", halted, 1);
        halt_resume();

        // Asynchronous reset in the middle of FWAIT.
        m_ret_total = m_ret_total;
        cyc(1'b0, 1'b0, 1'b0, M_IRD, ST_FETCH);
        cyc(1'b0, 1'b0, 1'b0, M_IRD, ST_FWAIT);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ctrlsig", ctrlsig, 0);
        check("mid_rst_state",   state_dbg, 0);
        check("mid_rst_busy",    busy, 0);
        check("mid_rst_fault",   fault, 0);
        check("mid_rst_retired", retired, 0);
        #4 reset = 1'b1;
        m_ret_total = 0;
        m_fault     = 2'b00;
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 1'b0, 13'h0, ST_IDLE);
        cyc(1'b0, 1'b1, 1'b0, 13'h0, ST_IDLE);
        cyc(1'b1, 1'b1, 1'b0, 13'h0, ST_IDLE);

        // Five NOPs walk the 2-bit retired counter through its wrap.
        for (int k = 0; k < 5; k++) begin
            run_instr(8'h00, 1'b0, 0, 0);
            check("nop_retired", retired, nop_seq[k]);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
